// File: rtl/mem_bank_accumulator_if.sv
// Sample stream plus banked-memory command bus around the accumulator.
// The master side is the accumulator itself: it answers the sample
// handshake and drives the memory read, write and clear commands.
interface mem_bank_accumulator_if #(
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH      = 32,
   parameter int NUM_BANKS  = 2
);
   localparam int BW = $clog2(NUM_BANKS);
   localparam int AW = $clog2(DEPTH);

   // Sample stream
   logic                  in_valid;
   logic                  in_ready;
   logic [BW-1:0]         in_bank;
   logic [AW-1:0]         in_addr;
   logic [DATA_WIDTH-1:0] in_sample;

   // Memory clear handshake
   logic                  mem_reset_mem;
   logic                  mem_reset_done;

   // Memory read port
   logic                  mem_reb;
   logic [BW-1:0]         mem_bankb;
   logic [AW-1:0]         mem_addrb;
   logic [DATA_WIDTH-1:0] mem_dob;

   // Memory write port
   logic                  mem_wea;
   logic [BW-1:0]         mem_banka;
   logic [AW-1:0]         mem_addra;
   logic [DATA_WIDTH-1:0] mem_dia;

   modport master (
      input  in_valid, in_bank, in_addr, in_sample, mem_reset_done, mem_dob,
      output in_ready, mem_reset_mem, mem_reb, mem_bankb, mem_addrb,
             mem_wea, mem_banka, mem_addra, mem_dia
   );

   modport slave (
      output in_valid, in_bank, in_addr, in_sample, mem_reset_done, mem_dob,
      input  in_ready, mem_reset_mem, mem_reb, mem_bankb, mem_addrb,
             mem_wea, mem_banka, mem_addra, mem_dia
   );
endinterface

// File: rtl/mem_bank_accumulator.sv
// Read-modify-write saturating accumulator in front of a banked memory.
// Reads are issued on accept, the sum is written READ_LATENCY cycles later,
// and a short history of recent writes is forwarded over stale read data.
// Full-memory clears are sequenced through the memory's reset handshake.
module mem_bank_accumulator #(
   parameter int DATA_WIDTH   = 24,
   parameter int DEPTH        = 32,
   parameter int NUM_BANKS    = 2,
   parameter int READ_LATENCY = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic clear_done,
   output logic saturated,
   mem_bank_accumulator_if.master bus
);
   localparam int BW = $clog2(NUM_BANKS);
   localparam int AW = $clog2(DEPTH);
   localparam int W  = DATA_WIDTH;
   localparam int RL = READ_LATENCY;

   typedef enum logic [1:0] {RUN, DRAIN, CLEAR_REQ, CLEARING} state_t;

   state_t state_q, state_d;

   // Tag pipeline: slot RL-1 is the write stage
   logic [RL-1:0] pv_q, pv_d;
   logic [BW-1:0] pbank_q [RL];
   logic [BW-1:0] pbank_d [RL];
   logic [AW-1:0] paddr_q [RL];
   logic [AW-1:0] paddr_d [RL];
   logic [W-1:0]  psmp_q  [RL];
   logic [W-1:0]  psmp_d  [RL];

   // Write history: slot 0 is the youngest write
   logic [RL-1:0] hv_q, hv_d;
   logic [BW-1:0] hbank_q [RL];
   logic [BW-1:0] hbank_d [RL];
   logic [AW-1:0] haddr_q [RL];
   logic [AW-1:0] haddr_d [RL];
   logic [W-1:0]  hdata_q [RL];
   logic [W-1:0]  hdata_d [RL];

   logic clear_done_q, clear_done_d;
   logic saturated_q, saturated_d;

   logic         ready;
   logic         accept;
   logic         wr_valid;
   logic         clamp;
   logic         clear_finish;
   logic [W-1:0] old_data;
   logic [W:0]   sum;
   logic [W-1:0] wr_data;

   assign clear_done = clear_done_q;
   assign saturated  = saturated_q;

   // Sample handshake and same-cycle read command
   always_comb begin
      ready         = (state_q == RUN) && !clear;
      accept        = bus.in_valid && ready;
      bus.in_ready  = ready;
      bus.mem_reb   = accept;
      bus.mem_bankb = accept ? bus.in_bank : '0;
      bus.mem_addrb = accept ? bus.in_addr : '0;
   end

   // Write stage: forward youngest matching history entry, add, clamp
   always_comb begin
      old_data = bus.mem_dob;
      for (int i = RL - 1; i >= 0; i--) begin
         if (hv_q[i] && (hbank_q[i] == pbank_q[RL-1]) && (haddr_q[i] == paddr_q[RL-1])) begin
            old_data = hdata_q[i];
         end
      end
      sum   = {old_data[W-1], old_data} + {psmp_q[RL-1][W-1], psmp_q[RL-1]};
      clamp = sum[W] ^ sum[W-1];
      if (!clamp) begin
         wr_data = sum[W-1:0];
      end else if (sum[W]) begin
         wr_data = {1'b1, {(W-1){1'b0}}};
      end else begin
         wr_data = {1'b0, {(W-1){1'b1}}};
      end
      wr_valid      = pv_q[RL-1] && ((state_q == RUN) || (state_q == DRAIN));
      bus.mem_wea   = wr_valid;
      bus.mem_banka = wr_valid ? pbank_q[RL-1] : '0;
      bus.mem_addra = wr_valid ? paddr_q[RL-1] : '0;
      bus.mem_dia   = wr_valid ? wr_data       : '0;
   end

   // Clear sequencing and sticky saturation flag
   always_comb begin
      state_d           = state_q;
      clear_done_d      = 1'b0;
      saturated_d       = saturated_q | (wr_valid & clamp);
      clear_finish      = 1'b0;
      bus.mem_reset_mem = 1'b0;
      case (state_q)
         RUN:       if (clear) state_d = DRAIN;
         DRAIN:     if (pv_q == '0) state_d = CLEAR_REQ;
         CLEAR_REQ: begin
            bus.mem_reset_mem = 1'b1;
            state_d           = CLEARING;
         end
         CLEARING:  if (bus.mem_reset_done) begin
            state_d      = RUN;
            clear_done_d = 1'b1;
            saturated_d  = 1'b0;
            clear_finish = 1'b1;
         end
         default:   state_d = RUN;
      endcase
   end

   // Next values for the tag pipeline and the write history shift registers
   always_comb begin
      pv_d[0]    = accept;
      pbank_d[0] = bus.in_bank;
      paddr_d[0] = bus.in_addr;
      psmp_d[0]  = bus.in_sample;
      hv_d[0]    = wr_valid && !clear_finish;
      hbank_d[0] = pbank_q[RL-1];
      haddr_d[0] = paddr_q[RL-1];
      hdata_d[0] = wr_data;
      for (int i = 1; i < RL; i++) begin
         pv_d[i]    = pv_q[i-1];
         pbank_d[i] = pbank_q[i-1];
         paddr_d[i] = paddr_q[i-1];
         psmp_d[i]  = psmp_q[i-1];
         hv_d[i]    = hv_q[i-1] && !clear_finish;
         hbank_d[i] = hbank_q[i-1];
         haddr_d[i] = haddr_q[i-1];
         hdata_d[i] = hdata_q[i-1];
      end
   end

   // State, flags, pipeline and history registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RUN;
         clear_done_q <= 1'b0;
         saturated_q  <= 1'b0;
         pv_q         <= '0;
         hv_q         <= '0;
         for (int i = 0; i < RL; i++) begin
            pbank_q[i] <= '0;
            paddr_q[i] <= '0;
            psmp_q[i]  <= '0;
            hbank_q[i] <= '0;
            haddr_q[i] <= '0;
            hdata_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         clear_done_q <= clear_done_d;
         saturated_q  <= saturated_d;
         pv_q         <= pv_d;
         hv_q         <= hv_d;
         for (int i = 0; i < RL; i++) begin
            pbank_q[i] <= pbank_d[i];
            paddr_q[i] <= paddr_d[i];
            psmp_q[i]  <= psmp_d[i];
            hbank_q[i] <= hbank_d[i];
            haddr_q[i] <= haddr_d[i];
            hdata_q[i] <= hdata_d[i];
         end
      end
   end
endmodule

// File: tb/tb_mem_bank_accumulator.sv
// Bench for mem_bank_accumulator: behavioural banked memory with read-first
// ordering and a 64-cycle clear handshake, a reference memory that predicts
// every write, and directed tests followed by a random stress run.
`timescale 1ns/1ps
module tb_mem_bank_accumulator;
   localparam int W  = 24;
   localparam int D  = 32;
   localparam int NB = 2;
   localparam int RL = 2;
   localparam int BW = 1;
   localparam int AW = 5;

   typedef struct packed {
      logic [BW-1:0] bank;
      logic [AW-1:0] addr;
      logic [W-1:0]  smp;
      logic [31:0]   due;
   } acc_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clear = 1'b0;
   logic clear_done;
   logic saturated;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit verbose = 1'b1;
   bit exp_acc = 1'b0;
   bit chk_t2 = 1'b0;
   int clr_cyc = 0;

   // Monitor-owned state
   acc_t         pend [$];
   logic [W-1:0] wr_log [$];
   int           wr_cyc [$];
   logic [W-1:0] ref_mem [NB*D];
   bit           ref_init = 1'b0;
   bit           exp_sat = 1'b0;
   bit           rd_seen = 1'b0;
   int           rd_cyc = 0;
   int           mrm_cnt = 0;

   // Memory-model state
   logic [W-1:0] mem_model [NB*D];
   logic [W-1:0] rd_pipe [RL];
   bit           mem_init = 1'b0;
   int           rst_cnt = 0;
   logic         done_r = 1'b0;

   mem_bank_accumulator_if #(.DATA_WIDTH(W), .DEPTH(D), .NUM_BANKS(NB)) bus ();

   mem_bank_accumulator #(
      .DATA_WIDTH(W), .DEPTH(D), .NUM_BANKS(NB), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .clear_done(clear_done), .saturated(saturated), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b, output bit cl);
      longint s;
      s  = longint'($signed(a)) + longint'($signed(b));
      cl = 1'b0;
      if (s > 64'sd8388607) begin
         s  = 64'sd8388607;
         cl = 1'b1;
      end else if (s < -64'sd8388608) begin
         s  = -64'sd8388608;
         cl = 1'b1;
      end
      return s[W-1:0];
   endfunction

   function automatic logic [31:0] log_at(input int i);
      if (i < wr_log.size()) return 32'(wr_log[i]);
      return 32'hDEAD_BEEF;
   endfunction

   // Banked memory: read-first, RL-cycle read pipe, self-clear 64 cycles after request
   assign bus.mem_dob        = rd_pipe[RL-1];
   assign bus.mem_reset_done = done_r;
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < RL; i++) rd_pipe[i] <= '0;
         rst_cnt <= 0;
         done_r  <= 1'b0;
         if (!mem_init) begin
            for (int i = 0; i < NB*D; i++) mem_model[i] <= W'(i * 37 + 100);
            mem_init <= 1'b1;
         end
      end else begin
         rd_pipe[0] <= bus.mem_reb ? mem_model[int'({bus.mem_bankb, bus.mem_addrb})] : '0;
         for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
         if (bus.mem_wea) mem_model[int'({bus.mem_banka, bus.mem_addra})] <= bus.mem_dia;
         done_r <= 1'b0;
         if (bus.mem_reset_mem) begin
            rst_cnt <= 64;
         end else if (rst_cnt > 0) begin
            rst_cnt <= rst_cnt - 1;
            if (rst_cnt == 1) begin
               done_r <= 1'b1;
               for (int i = 0; i < NB*D; i++) mem_model[i] <= '0;
            end
         end
      end
   end

   // Scoreboard monitor, sampled mid-cycle
   always @(negedge clk) begin
      acc_t         e;
      bit           exp_we;
      bit           exp_cd;
      bit           cl;
      logic [W-1:0] expd;
      if (!reset_n) begin
         pend.delete();
         exp_sat = 1'b0;
         rd_seen = 1'b0;
         if (!ref_init) begin
            for (int i = 0; i < NB*D; i++) ref_mem[i] = W'(i * 37 + 100);
            ref_init = 1'b1;
         end
      end else begin
         exp_we = (pend.size() > 0) && (pend[0].due == 32'(cyc));
         if (exp_we || bus.mem_wea) begin
            check_val("mem_wea", 32'(bus.mem_wea), 32'(exp_we));
            if (exp_we) begin
               e = pend.pop_front();
               expd = sat_add(ref_mem[int'({e.bank, e.addr})], e.smp, cl);
               ref_mem[int'({e.bank, e.addr})] = expd;
               if (cl) exp_sat = 1'b1;
               if (bus.mem_wea) begin
                  check_val("mem_banka", 32'(bus.mem_banka), 32'(e.bank));
                  check_val("mem_addra", 32'(bus.mem_addra), 32'(e.addr));
                  check_val("mem_dia", 32'(bus.mem_dia), 32'(expd));
               end
            end
            if (bus.mem_wea) begin
               wr_log.push_back(bus.mem_dia);
               wr_cyc.push_back(cyc);
               if (verbose) $display("WR  cyc=%0d bank=%0d addr=%0d data=%06h", cyc, bus.mem_banka, bus.mem_addra, bus.mem_dia);
            end
         end
         if (bus.mem_reset_mem) begin
            check_val("drained_before_clear", 32'(pend.size()), 0);
            if (chk_t2) check_val("reset_mem_cycle", 32'(cyc), 32'(clr_cyc + 2));
            mrm_cnt++;
         end
         exp_cd = rd_seen && (cyc == rd_cyc + 1);
         if (exp_cd || clear_done) begin
            check_val("clear_done", 32'(clear_done), 32'(exp_cd));
            if (exp_cd) check_val("sat_after_clear", 32'(saturated), 0);
         end
         if (bus.mem_reset_done) begin
            rd_seen = 1'b1;
            rd_cyc  = cyc;
            exp_sat = 1'b0;
            for (int i = 0; i < NB*D; i++) ref_mem[i] = '0;
         end
         if (bus.in_valid && exp_acc) begin
            e.bank = bus.in_bank;
            e.addr = bus.in_addr;
            e.smp  = bus.in_sample;
            e.due  = 32'(cyc + RL);
            pend.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [W-1:0] s);
      bus.in_valid  = 1'b1;
      bus.in_bank   = b;
      bus.in_addr   = a;
      bus.in_sample = s;
      exp_acc       = 1'b1;
      #1;
      check_val("mem_reb", 32'(bus.mem_reb), 1);
      check_val("mem_addrb", 32'(bus.mem_addrb), 32'(a));
      step();
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      exp_acc      = 1'b0;
      repeat (n) step();
   endtask

   task automatic wait_clear_done();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         step();
         if (clear_done) got = 1'b1;
      end
      check_val("clear_done_seen", 32'(got), 1);
      if (got) begin
         check_val("ready_at_done", 32'(bus.in_ready), 1);
         check_val("sat_at_done", 32'(saturated), 0);
         if (verbose) $display("CLR done at cyc=%0d", cyc);
      end
   endtask

   // Raises clear for one cycle; any sample already on the bus must be refused
   task automatic do_clear(input bit t2);
      chk_t2  = t2;
      exp_acc = 1'b0;
      clear   = 1'b1;
      clr_cyc = cyc;
      #1;
      check_val("in_ready_on_clear", 32'(bus.in_ready), 0);
      check_val("mem_reb_on_clear", 32'(bus.mem_reb), 0);
      step();
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      wait_clear_done();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int a0;
      int n;
      int m0;
      bit got;
      bus.in_valid  = 1'b0;
      bus.in_bank   = '0;
      bus.in_addr   = '0;
      bus.in_sample = '0;
      repeat (3) step();

      // Reset values
      check_val("rst_in_ready", 32'(bus.in_ready), 1);
      check_val("rst_mem_reb", 32'(bus.mem_reb), 0);
      check_val("rst_mem_wea", 32'(bus.mem_wea), 0);
      check_val("rst_reset_mem", 32'(bus.mem_reset_mem), 0);
      check_val("rst_clear_done", 32'(clear_done), 0);
      check_val("rst_saturated", 32'(saturated), 0);
      check_val("rst_mem_dia", 32'(bus.mem_dia), 0);
      reset_n = 1'b1;
      step();

      // Single accumulate from a cleared memory; second add is a fresh read
      do_clear(1'b1);
      base = wr_log.size();
      send(1, 3, 24'd5);
      idle(10);
      send(1, 3, -24'sd2);
      idle(4);
      check_val("acc_first", log_at(base), 32'd5);
      check_val("acc_second", log_at(base + 1), 32'd3);

      // Back-to-back hits on one word
      base = wr_log.size();
      a0 = cyc;
      send(0, 7, 24'd1);
      send(0, 7, 24'd2);
      send(0, 7, 24'd3);
      idle(4);
      check_val("hazard_w0", log_at(base), 32'd1);
      check_val("hazard_w1", log_at(base + 1), 32'd3);
      check_val("hazard_w2", log_at(base + 2), 32'd6);
      if (wr_cyc.size() >= base + 3) begin
         check_val("hazard_lat", 32'(wr_cyc[base]), 32'(a0 + 2));
         check_val("hazard_gap", 32'(wr_cyc[base + 2] - wr_cyc[base]), 32'd2);
      end else begin
         check_val("hazard_count", 32'(wr_cyc.size() - base), 32'd3);
      end

      // Saturation at both rails
      base = wr_log.size();
      send(0, 1, 24'h7FFFF0);
      idle(3);
      check_val("sat_pre", 32'(saturated), 0);
      send(0, 1, 24'h000020);
      idle(3);
      send(0, 2, 24'h800000);
      idle(3);
      send(0, 2, 24'hFFFFFF);
      idle(3);
      check_val("sat_pos_store", log_at(base), 32'h7FFFF0);
      check_val("sat_pos", log_at(base + 1), 32'h7FFFFF);
      check_val("sat_neg_store", log_at(base + 2), 32'h800000);
      check_val("sat_neg", log_at(base + 3), 32'h800000);
      check_val("sat_flag", 32'(saturated), 1);

      // Async reset mid-pipeline: in-flight writes vanish
      send(1, 9, 24'd10);
      send(0, 9, 24'd20);
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      exp_acc      = 1'b0;
      #1;
      check_val("arst_mem_wea", 32'(bus.mem_wea), 0);
      check_val("arst_mem_dia", 32'(bus.mem_dia), 0);
      check_val("arst_mem_addra", 32'(bus.mem_addra), 0);
      check_val("arst_saturated", 32'(saturated), 0);
      check_val("arst_in_ready", 32'(bus.in_ready), 1);
      repeat (3) step();
      base = wr_log.size();
      reset_n = 1'b1;
      idle(6);
      check_val("arst_no_write", 32'(wr_log.size() - base), 0);

      // Clear during traffic: two in flight, a third refused by the clear
      send(0, 1, 24'h000020);
      idle(3);
      check_val("sat_before_clear", 32'(saturated), 1);
      send(1, 5, 24'd7);
      send(0, 9, 24'd11);
      bus.in_valid  = 1'b1;
      bus.in_bank   = 1;
      bus.in_addr   = 5;
      bus.in_sample = 24'd100;
      do_clear(1'b0);
      base = wr_log.size();
      send(1, 5, 24'd4);
      send(0, 9, -24'sd3);
      idle(4);
      check_val("post_clear_a", log_at(base), 32'd4);
      check_val("post_clear_b", log_at(base + 1), 32'hFFFFFD);

      // Async reset while CLEARING
      m0 = mrm_cnt;
      clear = 1'b1;
      step();
      clear = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (mrm_cnt != m0) got = 1'b1;
      end
      check_val("mid_clear_req_seen", 32'(got), 1);
      repeat (10) step();
      reset_n = 1'b0;
      #1;
      check_val("mclr_reset_mem", 32'(bus.mem_reset_mem), 0);
      check_val("mclr_in_ready", 32'(bus.in_ready), 1);
      check_val("mclr_clear_done", 32'(clear_done), 0);
      repeat (3) step();
      base = wr_log.size();
      reset_n = 1'b1;
      idle(70);
      check_val("mclr_in_ready_after", 32'(bus.in_ready), 1);
      check_val("mclr_no_write", 32'(wr_log.size() - base), 0);

      // Random stress against the reference memory
      verbose = 1'b0;
      n = 0;
      while (n < 10000) begin
         if ($urandom_range(0, 9) != 0) begin
            logic [AW-1:0] a;
            logic [W-1:0]  s;
            a = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, D - 1));
            s = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'(int'($urandom_range(0, 2000)) - 1000);
            send(BW'($urandom_range(0, NB - 1)), a, s);
            n++;
         end else begin
            idle(1);
         end
      end
      idle(5);
      verbose = 1'b1;
      check_val("stress_pending", 32'(pend.size()), 0);
      check_val("stress_saturated", 32'(saturated), 32'(exp_sat));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
